// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase controller.
// Phase codes and lamp encodings used by the FSM and its observers.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_A_GRN = 3'd0,
        PH_A_YEL = 3'd1,
        PH_CLR_A = 3'd2,
        PH_B_GRN = 3'd3,
        PH_B_YEL = 3'd4,
        PH_CLR_B = 3'd5,
        PH_WALK  = 3'd6
    } phase_t;

    localparam logic [1:0] LAMP_GRN = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_RED = 2'b10;

endpackage

// File: rtl/phase_timer.sv
// Elapsed-cycle counter for the current phase.
// Ports: clk, rst_n (async low), clr (sync clear), el (saturating count).
module phase_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic [CW-1:0] el
);

    localparam logic [CW-1:0] EL_MAX = '1;

    logic [CW-1:0] el_d;
    logic [CW-1:0] el_q;

    always_comb begin
        el_d = el_q;
        if (clr) begin
            el_d = '0;
        end else if (el_q != EL_MAX) begin
            el_d = el_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            el_q <= '0;
        end else begin
            el_q <= el_d;
        end
    end

    assign el = el_q;

endmodule

// File: rtl/light_phase_ctrl.sv
// Timed two-road phase controller with pedestrian all-red WALK phase.
// Ports: CLK, RESETB, TA/TB sensors, PED button; LA/LB/WALK lamps, PHASE.
module light_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 6,
    parameter int CW        = 5
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       TA,
    input  logic       TB,
    input  logic       PED,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       WALK,
    output logic [2:0] PHASE
);

    localparam logic [CW-1:0] G_MIN_M1 = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] G_MAX_M1 = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] Y_M1     = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] R_M1     = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] W_M1     = CW'(WALK_T - 1);

    phase_t        state_d, state_q;
    logic          pp_d, pp_q;
    logic          nb_d, nb_q;
    logic [CW-1:0] el;
    logic          enter_walk;

    phase_timer #(.CW(CW)) u_timer (
        .clk   (CLK),
        .rst_n (RESETB),
        .clr   (state_d != state_q),
        .el    (el)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_A_GRN: begin
                if (el >= G_MIN_M1 && (TB || pp_q) &&
                    (!TA || el >= G_MAX_M1)) begin
                    state_d = PH_A_YEL;
                end
            end
            PH_A_YEL: if (el == Y_M1) state_d = PH_CLR_A;
            PH_CLR_A: begin
                if (el == R_M1) begin
                    state_d = pp_q ? PH_WALK : PH_B_GRN;
                end
            end
            PH_B_GRN: begin
                if (el >= G_MIN_M1 && (TA || pp_q) &&
                    (!TB || el >= G_MAX_M1)) begin
                    state_d = PH_B_YEL;
                end
            end
            PH_B_YEL: if (el == Y_M1) state_d = PH_CLR_B;
            PH_CLR_B: begin
                if (el == R_M1) begin
                    state_d = pp_q ? PH_WALK : PH_A_GRN;
                end
            end
            PH_WALK: begin
                if (el == W_M1) begin
                    state_d = nb_q ? PH_B_GRN : PH_A_GRN;
                end
            end
            default: state_d = PH_A_GRN;
        endcase
    end

    // The entering edge clears the request and wins over a fresh press.
    assign enter_walk = (state_d == PH_WALK) && (state_q != PH_WALK);

    always_comb begin
        pp_d = pp_q;
        nb_d = nb_q;
        if (enter_walk) begin
            pp_d = 1'b0;
            nb_d = (state_q == PH_CLR_A);
        end else if (PED && state_q != PH_WALK) begin
            pp_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= PH_A_GRN;
            pp_q    <= 1'b0;
            nb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pp_q    <= pp_d;
            nb_q    <= nb_d;
        end
    end

    always_comb begin
        LA   = LAMP_RED;
        LB   = LAMP_RED;
        WALK = 1'b0;
        case (state_q)
            PH_A_GRN: LA   = LAMP_GRN;
            PH_A_YEL: LA   = LAMP_YEL;
            PH_B_GRN: LB   = LAMP_GRN;
            PH_B_YEL: LB   = LAMP_YEL;
            PH_WALK:  WALK = 1'b1;
            default:  ;
        endcase
    end

    assign PHASE = state_q;

endmodule
